// File: rtl/dm_ctrl_if.sv
// dm_ctrl_if -- request/response bundle between the MEM stage and dm_ctrl.
//
// Parameters:
//   ADDR_W  byte-address width (must match the dm_ctrl instance)
// Signals:
//   req, we, addr, wdata, mode, sext   requester -> memory controller
//   ready, rvalid, rdata, exc          memory controller -> requester
// Modports:
//   master  pipeline side (drives the request)
//   slave   dm_ctrl side (drives ready/response)
//
// Access-size codes: MEM_op_byte / MEM_op_half normally come from
// declarations.v. The fallbacks below are used only when that file has not
// been read first. Every other mode code means a word access.

`ifndef MEM_op_byte
`define MEM_op_byte 2'b00
`endif
`ifndef MEM_op_half
`define MEM_op_half 2'b01
`endif

interface dm_ctrl_if #(
  parameter int ADDR_W = 12
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic [1:0]        mode;
  logic              sext;
  logic              ready;
  logic              rvalid;
  logic [31:0]       rdata;
  logic              exc;

  modport master (
    output req, we, addr, wdata, mode, sext,
    input  ready, rvalid, rdata, exc
  );

  modport slave (
    input  req, we, addr, wdata, mode, sext,
    output ready, rvalid, rdata, exc
  );
endinterface

// File: rtl/dm_ctrl.sv
// dm_ctrl -- handshaked, latency-configurable data memory for the MEM stage.
//
// A request is accepted in IDLE, waits in WAIT, and the single byte/half/word
// access is performed on the edge that enters RESP. RESP drives a one-cycle
// rvalid pulse and then the controller returns to IDLE.
//
// Parameters:
//   ADDR_W   byte-address width, depth = 2**(ADDR_W-2) words (3..20)
//   LATENCY  wait cycles between accept and access (0..15)
// Ports:
//   clk      clock, rising edge
//   rst_n    asynchronous active-low reset
//   bus      dm_ctrl_if.slave: req/we/addr/wdata/mode/sext in,
//            ready/rvalid/rdata/exc out
//
// Optional feature macro: DM_MISALIGN_EXC_EN
//   defined     misaligned half/word accesses raise exc, stores are dropped
//               and loads return 0
//   undefined   offending low address bits are ignored and exc stays 0

module dm_ctrl #(
  parameter int ADDR_W  = 12,
  parameter int LATENCY = 1
) (
  input logic     clk,
  input logic     rst_n,
  dm_ctrl_if.slave bus
);

  localparam int         DEPTH    = 1 << (ADDR_W - 2);
  // The counter runs LATENCY..0 inside WAIT, so the access lands on the
  // edge E0+LATENCY+1 after the accept edge E0.
  localparam logic [3:0] CNT_INIT = 4'(LATENCY);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t            state_reg;
  logic [3:0]        cnt_reg;
  logic              we_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [31:0]       wdata_reg;
  logic [1:0]        mode_reg;
  logic              sext_reg;
  logic              ready_reg;
  logic              rvalid_reg;
  logic [31:0]       rdata_reg;
  logic              exc_reg;

  // Not reset: contents are undefined after power-up.
  logic [31:0] mem [DEPTH];

  logic        access;
  logic        is_byte;
  logic        is_half;
  logic        drop;
  logic [1:0]  lane;
  logic [3:0]  be;
  logic [31:0] wlane;
  logic [31:0] word_rd;
  logic [7:0]  byte_rd;
  logic [15:0] half_rd;
  logic [31:0] load_val;

  assign access = (state_reg == WAIT) && (cnt_reg == 4'd0);

  always_comb begin
    is_byte = (mode_reg == `MEM_op_byte);
    is_half = (mode_reg == `MEM_op_half);
`ifdef DM_MISALIGN_EXC_EN
    drop = (is_half && addr_reg[0]) ||
           (!is_byte && !is_half && (addr_reg[1:0] != 2'b00));
`else
    drop = 1'b0;
`endif
    // Low address bits that do not fit the access size are simply ignored.
    if (is_byte)      lane = addr_reg[1:0];
    else if (is_half) lane = {addr_reg[1], 1'b0};
    else              lane = 2'b00;

    if (is_byte) begin
      be    = 4'b0001 << lane;
      wlane = {4{wdata_reg[7:0]}};
    end else if (is_half) begin
      be    = 4'b0011 << lane;
      wlane = {2{wdata_reg[15:0]}};
    end else begin
      be    = 4'b1111;
      wlane = wdata_reg;
    end

    word_rd = mem[addr_reg[ADDR_W-1:2]];
    case (lane)
      2'd0:    byte_rd = word_rd[7:0];
      2'd1:    byte_rd = word_rd[15:8];
      2'd2:    byte_rd = word_rd[23:16];
      default: byte_rd = word_rd[31:24];
    endcase
    half_rd = lane[1] ? word_rd[31:16] : word_rd[15:0];

    if (is_byte)
      load_val = {{24{sext_reg & byte_rd[7]}}, byte_rd};
    else if (is_half)
      load_val = {{16{sext_reg & half_rd[15]}}, half_rd};
    else
      load_val = word_rd;
  end

  // Byte-lane writes; unselected lanes keep their contents.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      always_ff @(posedge clk) begin
        if (access && we_reg && !drop && be[gi])
          mem[addr_reg[ADDR_W-1:2]][8*gi +: 8] <= wlane[8*gi +: 8];
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      cnt_reg    <= 4'd0;
      we_reg     <= 1'b0;
      addr_reg   <= '0;
      wdata_reg  <= 32'd0;
      mode_reg   <= 2'd0;
      sext_reg   <= 1'b0;
      ready_reg  <= 1'b1;
      rvalid_reg <= 1'b0;
      rdata_reg  <= 32'd0;
      exc_reg    <= 1'b0;
    end else begin
      rvalid_reg <= 1'b0;
      exc_reg    <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.req) begin
            we_reg    <= bus.we;
            addr_reg  <= bus.addr;
            wdata_reg <= bus.wdata;
            mode_reg  <= bus.mode;
            sext_reg  <= bus.sext;
            cnt_reg   <= CNT_INIT;
            ready_reg <= 1'b0;
            state_reg <= WAIT;
          end
        end
        WAIT: begin
          if (cnt_reg == 4'd0) begin
            state_reg  <= RESP;
            rvalid_reg <= 1'b1;
            exc_reg    <= drop;
            // Stores and rejected accesses report zero data.
            rdata_reg  <= (we_reg || drop) ? 32'd0 : load_val;
          end else begin
            cnt_reg <= cnt_reg - 4'd1;
          end
        end
        RESP: begin
          state_reg <= IDLE;
          ready_reg <= 1'b1;
        end
        default: begin
          state_reg <= IDLE;
          ready_reg <= 1'b1;
        end
      endcase
    end
  end

  assign bus.ready  = ready_reg;
  assign bus.rvalid = rvalid_reg;
  assign bus.rdata  = rdata_reg;
  assign bus.exc    = exc_reg;

endmodule

// File: tb/tb_dm_ctrl.sv
// tb_dm_ctrl -- directed, table-driven bench for dm_ctrl.
// Two instances: LATENCY=1 (functional table) and LATENCY=3 (timing,
// dropped requests and mid-operation reset).
`timescale 1ns/1ps

`ifndef MEM_op_byte
`define MEM_op_byte 2'b00
`endif
`ifndef MEM_op_half
`define MEM_op_half 2'b01
`endif

module tb_dm_ctrl;

  localparam logic [1:0] MB = `MEM_op_byte;
  localparam logic [1:0] MH = `MEM_op_half;
  localparam logic [1:0] MW = (2'b10 != MB && 2'b10 != MH) ? 2'b10 :
                              (2'b11 != MB && 2'b11 != MH) ? 2'b11 : 2'b00;
`ifdef DM_MISALIGN_EXC_EN
  localparam bit EXC = 1'b1;
`else
  localparam bit EXC = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst1_n;
  logic rst3_n;

  dm_ctrl_if #(.ADDR_W(12)) b1 ();
  dm_ctrl_if #(.ADDR_W(12)) b3 ();

  dm_ctrl #(.ADDR_W(12), .LATENCY(1)) dut1 (.clk(clk), .rst_n(rst1_n), .bus(b1.slave));
  dm_ctrl #(.ADDR_W(12), .LATENCY(3)) dut3 (.clk(clk), .rst_n(rst3_n), .bus(b3.slave));

  int errors = 0;
  int checks = 0;

  logic use3 = 1'b0;
  wire        cur_ready  = use3 ? b3.ready  : b1.ready;
  wire        cur_rvalid = use3 ? b3.rvalid : b1.rvalid;
  wire [31:0] cur_rdata  = use3 ? b3.rdata  : b1.rdata;
  wire        cur_exc    = use3 ? b3.exc    : b1.exc;

  typedef struct {
    bit          s;      // 0: LATENCY=1 instance, 1: LATENCY=3 instance
    logic        w;
    logic [11:0] a;
    logic [31:0] d;
    logic [1:0]  m;
    logic        x;
    logic [31:0] er;
    logic        ee;
    string       name;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic add(input bit s, input logic w, input logic [11:0] a, input logic [31:0] d,
                     input logic [1:0] m, input logic x, input logic [31:0] er,
                     input logic ee, input string name);
    vec_t v;
    v.s = s; v.w = w; v.a = a; v.d = d; v.m = m; v.x = x; v.er = er; v.ee = ee; v.name = name;
    vecs.push_back(v);
  endtask

  task automatic drive(input bit s, input logic r, input logic w, input logic [11:0] a,
                       input logic [31:0] d, input logic [1:0] m, input logic x);
    if (s) begin
      b3.req = r; b3.we = w; b3.addr = a; b3.wdata = d; b3.mode = m; b3.sext = x;
    end else begin
      b1.req = r; b1.we = w; b1.addr = a; b1.wdata = d; b1.mode = m; b1.sext = x;
    end
  endtask

  // One request; inputs are scrambled right after the accept edge so that
  // only the captured copy can produce the expected result.
  task automatic xact(input bit s, input logic w, input logic [11:0] a, input logic [31:0] d,
                      input logic [1:0] m, input logic x,
                      output logic [31:0] rd, output logic ex, output int lat);
    use3 = s;
    @(negedge clk);
    drive(s, 1'b1, w, a, d, m, x);
    @(posedge clk);
    #1 drive(s, 1'b0, ~w, ~a, ~d, ~m, ~x);
    lat = -1;
    rd  = 'x;
    ex  = 1'bx;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (cur_rvalid) begin
        lat = i;
        rd  = cur_rdata;
        ex  = cur_exc;
        break;
      end
    end
    @(negedge clk);
    $display("xact %s we=%0b addr=0x%03h mode=%0d sext=%0b -> rdata=0x%08h exc=%0b lat=%0d",
             s ? "L3" : "L1", w, a, m, x, rd, ex, lat);
  endtask

  initial begin
    logic [31:0] rd;
    logic        ex;
    int          lat;
    logic [7:0]  ready_mask;
    logic [7:0]  rvalid_mask;

    // ---------------- reset ----------------
    rst1_n = 1'b0;
    rst3_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 12'h0, 32'h0, MW, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 12'h0, 32'h0, MW, 1'b0);
    repeat (3) @(negedge clk);
    rst1_n = 1'b1;
    rst3_n = 1'b1;
    @(negedge clk);
    chk("reset_ready",  {31'd0, b1.ready},  32'd1);
    chk("reset_rvalid", {31'd0, b1.rvalid}, 32'd0);
    chk("reset_rdata",  b1.rdata,           32'd0);
    chk("reset_exc",    {31'd0, b1.exc},    32'd0);
    chk("reset_ready3", {31'd0, b3.ready},  32'd1);
    $display("reset: ready=%0b rvalid=%0b rdata=0x%08h exc=%0b",
             b1.ready, b1.rvalid, b1.rdata, b1.exc);

    // ---------------- vector table ----------------
    add(0, 1, 12'h010, 32'hDEADBEEF, MW, 0, 32'h00000000, 0,   "st_word");
    add(0, 0, 12'h010, 32'h0,        MW, 0, 32'hDEADBEEF, 0,   "ld_word");
    add(0, 1, 12'h013, 32'hFFFFFF80, MB, 0, 32'h00000000, 0,   "st_byte");
    add(0, 0, 12'h010, 32'h0,        MW, 0, 32'h80ADBEEF, 0,   "ld_word_after_byte");
    add(0, 0, 12'h013, 32'h0,        MB, 1, 32'hFFFFFF80, 0,   "ld_byte_sext");
    add(0, 0, 12'h013, 32'h0,        MB, 0, 32'h00000080, 0,   "ld_byte_zext");
    add(0, 0, 12'h012, 32'h0,        MH, 1, 32'hFFFF80AD, 0,   "ld_half_hi_sext");
    add(0, 0, 12'h010, 32'h0,        MH, 0, 32'h0000BEEF, 0,   "ld_half_lo_zext");
    add(0, 0, 12'h011, 32'h0,        MB, 1, 32'hFFFFFFBE, 0,   "ld_byte1_sext");
    add(0, 0, 12'h010, 32'h0,        MW, 1, 32'h80ADBEEF, 0,   "ld_word_sext_ignored");
    add(0, 1, 12'h014, 32'h00000000, MW, 0, 32'h00000000, 0,   "st_word_zero");
    add(0, 1, 12'h016, 32'hFFFFA5C3, MH, 0, 32'h00000000, 0,   "st_half_hi");
    add(0, 0, 12'h014, 32'h0,        MW, 0, 32'hA5C30000, 0,   "ld_word_after_half");
    add(0, 0, 12'h014, 32'h0,        MH, 1, 32'h00000000, 0,   "ld_half_lo_zero");
    add(0, 0, 12'h017, 32'h0,        MB, 1, 32'hFFFFFFA5, 0,   "ld_byte3_sext");
    add(0, 1, 12'h011, 32'h12345678, MW, 0, 32'h00000000, EXC, "st_word_misaligned");
    add(0, 0, 12'h010, 32'h0,        MW, 0, EXC ? 32'h80ADBEEF : 32'h12345678, 0, "ld_word_after_mis");
    add(0, 0, 12'h013, 32'h0,        MH, 1, EXC ? 32'h00000000 : 32'h00001234, EXC, "ld_half_misaligned");
    add(0, 0, 12'h011, 32'h0,        MB, 0, EXC ? 32'h000000BE : 32'h00000056, 0, "ld_byte_never_mis");
    add(1, 1, 12'h020, 32'h11223344, MW, 0, 32'h00000000, 0,   "l3_st_word");
    add(1, 0, 12'h020, 32'h0,        MW, 0, 32'h11223344, 0,   "l3_ld_word");

    foreach (vecs[k]) begin
      xact(vecs[k].s, vecs[k].w, vecs[k].a, vecs[k].d, vecs[k].m, vecs[k].x, rd, ex, lat);
      chk({vecs[k].name, "_rdata"}, rd, vecs[k].er);
      chk({vecs[k].name, "_exc"}, {31'd0, ex}, {31'd0, vecs[k].ee});
      chk({vecs[k].name, "_lat"}, lat, vecs[k].s ? 32'd4 : 32'd2);
    end

    // ---------------- LATENCY=3 timing and dropped req ----------------
    use3 = 1'b1;
    ready_mask  = 8'd0;
    rvalid_mask = 8'd0;
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b0, 12'h020, 32'h0, MW, 1'b0);
    @(posedge clk);
    #1 drive(1'b1, 1'b0, 1'b0, 12'h020, 32'h0, MW, 1'b0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      ready_mask[i]  = b3.ready;
      rvalid_mask[i] = b3.rvalid;
      if (b3.rvalid) chk("l3_timing_rdata", b3.rdata, 32'h11223344);
      // Pulse req during WAIT; it must be dropped.
      if (i == 1) b3.req = 1'b1;
      if (i == 2) b3.req = 1'b0;
    end
    $display("l3 timing: ready_mask=%08b rvalid_mask=%08b", ready_mask, rvalid_mask);
    chk("l3_ready_mask",  {24'd0, ready_mask},  32'h000000E0);
    chk("l3_rvalid_mask", {24'd0, rvalid_mask}, 32'h00000010);

    // ---------------- reset in the middle of a store ----------------
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b1, 12'h020, 32'hCAFEF00D, MW, 1'b0);
    @(posedge clk);
    #1 drive(1'b1, 1'b0, 1'b0, 12'h000, 32'h0, MW, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst3_n = 1'b0;
    @(negedge clk);
    rst3_n = 1'b1;
    rvalid_mask = 8'd0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      rvalid_mask[i] = b3.rvalid;
    end
    $display("mid reset: rvalid_mask=%08b ready=%0b", rvalid_mask, b3.ready);
    chk("midrst_no_rvalid", {24'd0, rvalid_mask}, 32'd0);
    chk("midrst_ready",     {31'd0, b3.ready},    32'd1);
    xact(1'b1, 1'b0, 12'h020, 32'h0, MW, 1'b0, rd, ex, lat);
    chk("midrst_mem_kept", rd, 32'h11223344);
    chk("midrst_lat", lat, 32'd4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
